// File: rtl/neuron_mac_unit_pkg.sv
// Shared types and helpers for the neuron MAC unit: FSM encoding,
// activation-mode codes and accumulator sizing.
package neuron_mac_unit_pkg;

    typedef enum logic [1:0] {IDLE, ACCUM, ACT, DONE} state_t;

    localparam logic AF_STEP = 1'b0;
    localparam logic AF_RELU = 1'b1;

    // Full-precision products plus enough guard bits that D products and the bias never wrap.
    function automatic int calc_aw(input int n, input int d);
        return 2 * n + $clog2(d + 1);
    endfunction

endpackage

// File: rtl/neuron_mac_unit_sat_activate.sv
// Rescales the raw accumulator to Q format, saturates it to N bits
// and applies the selected activation (step or ReLU).
module sat_activate
    import neuron_mac_unit_pkg::*;
#(
    parameter int N  = 16,
    parameter int Q  = 8,
    parameter int AW = 35
) (
    input  logic signed [AW-1:0] acc,
    input  logic                 af_mode,
    output logic        [N-1:0]  result,
    output logic                 ovf
);

    localparam logic signed [AW-1:0] MAX_V = {{(AW-N+1){1'b0}}, {(N-1){1'b1}}};
    localparam logic signed [AW-1:0] MIN_V = {{(AW-N+1){1'b1}}, {(N-1){1'b0}}};

    logic signed [AW-1:0] r;
    logic        [N-1:0]  sat;

    always_comb begin
        r   = acc >>> Q;
        ovf = 1'b0;
        sat = r[N-1:0];
        if (r > MAX_V) begin
            sat = MAX_V[N-1:0];
            ovf = 1'b1;
        end else if (r < MIN_V) begin
            sat = MIN_V[N-1:0];
            ovf = 1'b1;
        end
    end

    // ovf describes the clamp only; activation may still zero the value.
    always_comb begin
        result = '0;
        if (af_mode == AF_STEP) begin
            if (!sat[N-1] && (sat != '0))
                result = N'(1 << Q);
        end else if (!sat[N-1]) begin
            result = sat;
        end
    end

endmodule

// File: rtl/neuron_mac_unit.sv
// Single-neuron evaluator: bias preload, D streamed x*weight MACs into a
// guard-bit accumulator, then saturate + activate with a held result handshake.
module neuron_mac_unit
    import neuron_mac_unit_pkg::*;
#(
    parameter int N = 16,
    parameter int Q = 8,
    parameter int D = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] bias,
    input  logic         af_mode,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] x,
    input  logic [N-1:0] weight,
    output logic         busy,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] data_out,
    output logic         ovf
);

    localparam int AW = calc_aw(N, D);
    localparam int CW = (D > 1) ? $clog2(D) : 1;

    state_t               state;
    logic [CW-1:0]        cnt;
    logic signed [AW-1:0] acc;
    logic                 af_q;

    logic signed [2*N-1:0] prod;
    logic signed [AW-1:0]  prod_ext;
    logic signed [AW-1:0]  bias_ext;
    logic        [N-1:0]   act_res;
    logic                  act_ovf;

    assign prod     = $signed(x) * $signed(weight);
    assign prod_ext = {{(AW-2*N){prod[2*N-1]}}, prod};
    // Bias moves to the 2Q-fraction product scale so it adds straight in.
    assign bias_ext = {{(AW-N){bias[N-1]}}, bias} <<< Q;

    assign in_ready  = (state == ACCUM);
    assign busy      = (state != IDLE);
    assign out_valid = (state == DONE);

    sat_activate #(.N(N), .Q(Q), .AW(AW)) u_sat_act (
        .acc     (acc),
        .af_mode (af_q),
        .result  (act_res),
        .ovf     (act_ovf)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= '0;
            acc      <= '0;
            af_q     <= 1'b0;
            data_out <= '0;
            ovf      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        acc   <= bias_ext;
                        cnt   <= '0;
                        af_q  <= af_mode;
                        state <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (in_valid) begin
                        acc <= acc + prod_ext;
                        cnt <= cnt + CW'(1);
                        if (cnt == CW'(D - 1))
                            state <= ACT;
                    end
                end
                ACT: begin
                    data_out <= act_res;
                    ovf      <= act_ovf;
                    state    <= DONE;
                end
                DONE: begin
                    if (out_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_neuron_mac_unit.sv
// Scoreboard bench for neuron_mac_unit: a longint reference model pushes the
// expected result per evaluation; a monitor pops and compares on each handshake.
module tb_neuron_mac_unit;
    import neuron_mac_unit_pkg::*;

    localparam int N  = 16;
    localparam int Q  = 8;
    localparam int D  = 4;
    localparam int AW = calc_aw(N, D);

    typedef struct packed {
        logic [N-1:0] data;
        logic         ovf;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [N-1:0] bias = '0;
    logic         af_mode = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [N-1:0] x = '0;
    logic [N-1:0] weight = '0;
    logic         busy;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [N-1:0] data_out;
    logic         ovf;

    logic signed [AW-1:0] sa_acc = '0;
    logic                 sa_mode = 1'b0;
    logic [N-1:0]         sa_res;
    logic                 sa_ovf;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_chk = 0;
    int   n_err = 0;
    int   cyc = 0;

    neuron_mac_unit #(.N(N), .Q(Q), .D(D)) dut (
        .clk(clk), .rst(rst), .start(start), .bias(bias), .af_mode(af_mode),
        .in_valid(in_valid), .in_ready(in_ready), .x(x), .weight(weight),
        .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
        .data_out(data_out), .ovf(ovf)
    );

    sat_activate #(.N(N), .Q(Q), .AW(AW)) u_sa (
        .acc(sa_acc), .af_mode(sa_mode), .result(sa_res), .ovf(sa_ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [N-1:0] b, input logic m,
                                   input logic [D-1:0][N-1:0] xs,
                                   input logic [D-1:0][N-1:0] ws);
        longint acc, r, maxv, minv;
        exp_t   e;
        maxv = (longint'(1) << (N-1)) - 1;
        minv = -(longint'(1) << (N-1));
        acc  = longint'($signed(b)) * (longint'(1) << Q);
        for (int i = 0; i < D; i++)
            acc += longint'($signed(xs[i])) * longint'($signed(ws[i]));
        r     = acc >>> Q;
        e.ovf = 1'b0;
        if (r > maxv) begin r = maxv; e.ovf = 1'b1; end
        else if (r < minv) begin r = minv; e.ovf = 1'b1; end
        if (m == AF_STEP) e.data = (r > 0) ? N'(1 << Q) : '0;
        else              e.data = (r < 0) ? '0 : r[N-1:0];
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected_result", 32'd1, 32'd0);
            end else begin
                mon_e = sb_q.pop_front();
                check("data_out", 32'(data_out), 32'(mon_e.data));
                check("ovf", 32'(ovf), 32'(mon_e.ovf));
            end
        end
    end

    // vpat bit k = in_valid in the k-th ACCUM cycle; hold = cycles out_ready stays low in DONE;
    // poke = stray start pulses (with a different bias/mode) during ACCUM and DONE.
    task automatic run_eval(input logic [N-1:0] b, input logic m,
                            input logic [D-1:0][N-1:0] xs, input logic [D-1:0][N-1:0] ws,
                            input logic [15:0] vpat, input int hold, input bit poke,
                            input bit chk_lat);
        int           beats, k, t0;
        logic         ok;
        logic [N-1:0] d_hold;
        logic         o_hold;
        sb_q.push_back(model(b, m, xs, ws));
        @(posedge clk); #1;
        out_ready = (hold == 0);
        start = 1'b1; bias = b; af_mode = m; t0 = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        if (poke) begin bias = 16'h7000; af_mode = ~m; end
        beats = 0; k = 0;
        while (beats < D && k < 64) begin
            in_valid = (k < 16) ? vpat[k] : 1'b1;
            x = xs[beats]; weight = ws[beats];
            start = poke && (k == 1);
            ok = in_valid && in_ready;
            @(posedge clk); #1;
            if (ok) beats++;
            k++;
        end
        in_valid = 1'b0; start = 1'b0;
        check("beats_consumed", 32'(beats), 32'(D));
        check("in_ready_drop", 32'(in_ready), 32'd0);
        k = 0;
        while (!out_valid && k < 16) begin @(posedge clk); #1; k++; end
        check("out_valid_seen", 32'(out_valid), 32'd1);
        if (chk_lat) check("latency", 32'(cyc - t0), 32'(D + 2));
        if (hold > 0) begin
            d_hold = data_out; o_hold = ovf;
            for (int i = 0; i < hold; i++) begin
                start = poke;
                @(posedge clk); #1;
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_data", 32'(data_out), 32'(d_hold));
                check("hold_ovf", 32'(ovf), 32'(o_hold));
            end
            start = 1'b0;
            out_ready = 1'b1;
        end
        k = 0;
        while (busy && k < 16) begin @(posedge clk); #1; k++; end
        check("idle_return", 32'(busy), 32'd0);
        check("out_valid_drop", 32'(out_valid), 32'd0);
    endtask

    longint          sa_tab_acc [9] = '{32767*256, 32767*256+255, 32768*256, -32768*256,
                                        -32769*256, -1, 1, 256, 5*256};
    logic            sa_tab_m   [9] = '{1, 1, 1, 1, 0, 1, 0, 0, 1};
    logic [N-1:0]    sa_tab_r   [9] = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h0000, 16'h0000,
                                        16'h0000, 16'h0000, 16'h0100, 16'h0005};
    logic            sa_tab_o   [9] = '{0, 0, 1, 0, 1, 0, 0, 0, 0};

    logic [D-1:0][N-1:0] xs, ws;
    longint              tmp;

    initial begin
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_data_out", 32'(data_out), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);

        for (int i = 0; i < 9; i++) begin
            tmp = sa_tab_acc[i];
            sa_acc = tmp[AW-1:0]; sa_mode = sa_tab_m[i];
            #1;
            check($sformatf("sat_res%0d", i), 32'(sa_res), 32'(sa_tab_r[i]));
            check($sformatf("sat_ovf%0d", i), 32'(sa_ovf), 32'(sa_tab_o[i]));
        end

        @(posedge clk); #2 rst = 1'b1;

        run_eval(16'h0000, AF_RELU, {4{16'h0100}}, {4{16'h0080}}, 16'hFFFF, 0, 0, 1);
        run_eval(16'hFF00, AF_STEP, {4{16'h0100}}, {4{16'h0020}}, 16'hFFFF, 0, 0, 1);
        run_eval(16'h0000, AF_STEP, {4{16'h0100}}, {4{16'h0020}}, 16'hFFFF, 0, 0, 0);
        run_eval(16'h0000, AF_RELU, {4{16'h7FFF}}, {4{16'h7FFF}}, 16'hFFFF, 0, 0, 0);
        run_eval(16'h0000, AF_RELU, {4{16'h7FFF}}, {4{16'h8001}}, 16'hFFFF, 0, 0, 0);
        run_eval(16'h0000, AF_RELU, {4{16'h0100}}, {4{16'h0080}}, 16'h0059, 5, 0, 0);
        run_eval(16'h0000, AF_RELU, {4{16'h0100}}, {4{16'h0080}}, 16'h0059, 3, 1, 0);
        xs = {16'h0100, 16'h0080, 16'hFF00, 16'h0200};
        ws = {16'hFF80, 16'h0200, 16'h0100, 16'h0100};
        run_eval(16'h0100, AF_RELU, xs, ws, 16'hFFFF, 0, 0, 1);
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < D; i++) begin
                xs[i] = N'($urandom);
                ws[i] = N'($urandom_range(0, 16'h03FF)) - 16'h0200;
            end
            run_eval(N'($urandom), 1'($urandom), xs, ws, 16'($urandom) | 16'h8000,
                     $urandom_range(0, 3), 0, 0);
        end
        run_eval(16'h0000, AF_RELU, {4{16'h0100}}, {4{16'h0080}}, 16'hFFFF, 0, 0, 0);

        // Reset mid-evaluation after two beats; data_out is 0x0200 going in.
        @(posedge clk); #1;
        start = 1'b1; bias = 16'h0300; af_mode = AF_RELU;
        @(posedge clk); #1;
        start = 1'b0; in_valid = 1'b1; x = 16'h0100; weight = 16'h0080;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd0);
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_data_out", 32'(data_out), 32'd0);
        check("mid_rst_ovf", 32'(ovf), 32'd0);
        in_valid = 1'b0;
        @(posedge clk); #2 rst = 1'b1;
        run_eval(16'h0000, AF_RELU, {4{16'h0100}}, {4{16'h0080}}, 16'hFFFF, 0, 0, 1);

        repeat (3) @(posedge clk);
        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
